// File: rtl/bsg_hash_bank_iter_if.sv
// Request/response bundle for bsg_hash_bank_iter. The request side is ready/valid
// and the result side is valid/yumi.
interface bsg_hash_bank_iter_if #(
   parameter int width_p    = 16,
   parameter int lg_banks_p = 1
);
   logic [width_p-1:0]    i;
   logic                  v_i;
   logic                  ready_o;
   logic [lg_banks_p-1:0] bank_o;
   logic [width_p-1:0]    index_o;
   logic                  v_o;
   logic                  yumi_i;

   modport master (output i, v_i, yumi_i, input ready_o, bank_o, index_o, v_o);
   modport slave  (input i, v_i, yumi_i, output ready_o, bank_o, index_o, v_o);
endinterface

// File: rtl/bsg_hash_bank_iter.sv
// Address-to-bank hash: bank = i mod banks_p, index = i div banks_p.
// Power-of-two bank counts use a bit slice; other counts use a restoring divider.
module bsg_hash_bank_iter #(
   parameter int width_p = 16,
   parameter int banks_p = 1
) (
   input  logic                   clk_i,
   input  logic                   reset_n_i,
   bsg_hash_bank_iter_if.slave    hash_if
);
   localparam int LG_LP    = (banks_p > 1) ? $clog2(banks_p) : 1;
   localparam bit POW2_LP  = ((banks_p & (banks_p - 1)) == 0);
   localparam int SHIFT_LP = $clog2(banks_p);
   localparam int CNT_W_LP = (width_p > 1) ? $clog2(width_p) : 1;
   localparam logic [LG_LP+1:0]    BANKS_LP = (LG_LP+2)'(banks_p);
   localparam logic [CNT_W_LP-1:0] LAST_LP  = CNT_W_LP'(width_p - 1);

   if (banks_p < 1) begin : g_chk_min
      $error("bsg_hash_bank_iter: banks_p must be >= 1");
   end
   if ($clog2(banks_p) > width_p) begin : g_chk_max
      $error("bsg_hash_bank_iter: banks_p must be <= 2**width_p");
   end

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

   state_e                state_q, state_d;
   logic [LG_LP:0]        rem_q, rem_d;
   logic [width_p-1:0]    quot_q, quot_d;
   logic [CNT_W_LP-1:0]   cnt_q, cnt_d;
   logic [LG_LP-1:0]      bank_q, bank_d;
   logic [width_p-1:0]    index_q, index_d;
   logic [LG_LP+1:0]      rem_ext;
   logic [LG_LP:0]        rem_step;
   logic [width_p-1:0]    quot_step;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= IDLE;
         rem_q   <= '0;
         quot_q  <= '0;
         cnt_q   <= '0;
         bank_q  <= '0;
         index_q <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         quot_q  <= quot_d;
         cnt_q   <= cnt_d;
         bank_q  <= bank_d;
         index_q <= index_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      rem_d     = rem_q;
      quot_d    = quot_q;
      cnt_d     = cnt_q;
      bank_d    = bank_q;
      index_d   = index_q;
      // One restoring step: shift the next dividend bit in, subtract if it fits.
      rem_ext   = {rem_q, quot_q[width_p-1]};
      quot_step = quot_q << 1;
      rem_step  = rem_ext[LG_LP:0];
      if (rem_ext >= BANKS_LP) begin
         rem_step     = (LG_LP+1)'(rem_ext - BANKS_LP);
         quot_step[0] = 1'b1;
      end

      unique case (state_q)
         IDLE: begin
            if (hash_if.v_i) begin
               if (POW2_LP) begin
                  bank_d  = (banks_p == 1) ? '0 : hash_if.i[LG_LP-1:0];
                  index_d = hash_if.i >> SHIFT_LP;
                  state_d = DONE;
               end else begin
                  rem_d   = '0;
                  quot_d  = hash_if.i;
                  cnt_d   = '0;
                  state_d = BUSY;
               end
            end
         end
         BUSY: begin
            rem_d  = rem_step;
            quot_d = quot_step;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == LAST_LP) begin
               index_d = quot_step;
               bank_d  = rem_step[LG_LP-1:0];
               state_d = DONE;
            end
         end
         DONE: begin
            if (hash_if.yumi_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign hash_if.ready_o = (state_q == IDLE);
   assign hash_if.v_o     = (state_q == DONE);
   assign hash_if.bank_o  = bank_q;
   assign hash_if.index_o = index_q;

   a_yumi_needs_v: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      hash_if.yumi_i |-> hash_if.v_o)
      else $error("bsg_hash_bank_iter: yumi_i asserted while v_o=0");
endmodule

// File: tb/tb_bsg_hash_bank_iter.sv
// Directed bench for bsg_hash_bank_iter with four instances (banks 1, 4, 3, 6)
// checked every cycle against a latency/arithmetic model.
module tb_bsg_hash_bank_iter;
   localparam int N = 4;
   localparam int BANKS [N] = '{1, 4, 3, 6};

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] i_a    [N];
   logic        v_a    [N];
   logic        yumi_a [N];
   logic        ready_a[N];
   logic        vo_a   [N];
   logic [15:0] bank_a [N];
   logic [15:0] index_a[N];

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      localparam int B  = BANKS[g];
      localparam int LG = (B > 1) ? $clog2(B) : 1;
      bsg_hash_bank_iter_if #(.width_p(16), .lg_banks_p(LG)) bus ();
      bsg_hash_bank_iter #(.width_p(16), .banks_p(B)) dut (
         .clk_i    (clk),
         .reset_n_i(rst_n),
         .hash_if  (bus)
      );
      assign bus.i       = i_a[g];
      assign bus.v_i     = v_a[g];
      assign bus.yumi_i  = yumi_a[g];
      assign ready_a[g]  = bus.ready_o;
      assign vo_a[g]     = bus.v_o;
      assign bank_a[g]   = 16'(bus.bank_o);
      assign index_a[g]  = bus.index_o;
   end

   // Model: a request is either waiting out its latency, or holding a result.
   logic        m_busy [N];
   logic        m_valid[N];
   int          m_cnt  [N];
   logic [15:0] m_bank [N];
   logic [15:0] m_index[N];

   function automatic int lat_of(int d);
      return ((BANKS[d] & (BANKS[d] - 1)) == 0) ? 1 : 17;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      for (int d = 0; d < N; d++) begin
         if (!rst_n) begin
            m_busy[d]  <= 1'b0;
            m_valid[d] <= 1'b0;
            m_cnt[d]   <= 0;
            m_bank[d]  <= '0;
            m_index[d] <= '0;
         end else if (m_valid[d]) begin
            if (yumi_a[d]) m_valid[d] <= 1'b0;
         end else if (m_busy[d]) begin
            m_cnt[d] <= m_cnt[d] - 1;
            if (m_cnt[d] == 1) begin
               m_busy[d]  <= 1'b0;
               m_valid[d] <= 1'b1;
            end
         end else if (v_a[d]) begin
            m_bank[d]  <= 16'(int'(i_a[d]) % BANKS[d]);
            m_index[d] <= 16'(int'(i_a[d]) / BANKS[d]);
            if (lat_of(d) == 1) m_valid[d] <= 1'b1;
            else begin
               m_busy[d] <= 1'b1;
               m_cnt[d]  <= lat_of(d) - 1;
            end
         end
      end
   end

   task automatic chk(input string name, input int d, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s dut%0d (banks=%0d): got 0x%0h, expected 0x%0h at %0t",
                  name, d, BANKS[d], act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         for (int d = 0; d < N; d++) begin
            chk("model_v_o", d, int'(vo_a[d]), int'(m_valid[d]));
            chk("model_ready_o", d, int'(ready_a[d]), int'(!m_busy[d] && !m_valid[d]));
            if (m_valid[d]) begin
               chk("model_bank_o", d, int'(bank_a[d]), int'(m_bank[d]));
               chk("model_index_o", d, int'(index_a[d]), int'(m_index[d]));
            end
         end
      end
   end

   task automatic wait_ready(input int d);
      int n = 0;
      while (!ready_a[d] && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!ready_a[d]) chk("ready_timeout", d, 0, 1);
   endtask

   // Issue one request, measure latency, check literal results, then consume.
   task automatic req(input int d, input logic [15:0] addr, input int lat,
                      input int exp_bank, input int exp_index);
      int n;
      wait_ready(d);
      i_a[d] = addr;
      v_a[d] = 1'b1;
      @(negedge clk);
      v_a[d] = 1'b0;
      i_a[d] = ~addr;
      n = 1;
      while (!vo_a[d] && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("latency", d, n, lat);
      chk("bank_o", d, int'(bank_a[d]), exp_bank);
      chk("index_o", d, int'(index_a[d]), exp_index);
      if (vo_a[d]) begin
         yumi_a[d] = 1'b1;
         @(negedge clk);
         yumi_a[d] = 1'b0;
         chk("ready_after_yumi", d, int'(ready_a[d]), 1);
      end
   endtask

   initial begin
      for (int d = 0; d < N; d++) begin
         i_a[d] = '0;
         v_a[d] = 1'b0;
         yumi_a[d] = 1'b0;
      end
      repeat (2) @(negedge clk);
      for (int d = 0; d < N; d++) begin
         chk("reset_v_o", d, int'(vo_a[d]), 0);
         chk("reset_bank_o", d, int'(bank_a[d]), 0);
         chk("reset_index_o", d, int'(index_a[d]), 0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      for (int d = 0; d < N; d++) chk("ready_after_reset", d, int'(ready_a[d]), 1);

      req(0, 16'hABCD, 1, 0, 16'hABCD);
      req(1, 16'h1237, 1, 3, 16'h048D);
      req(2, 16'hFFFF, 17, 0, 16'h5555);
      req(2, 16'd100, 17, 1, 33);
      req(3, 16'd5, 17, 5, 0);
      req(3, 16'd0, 17, 0, 0);
      req(3, 16'hFFFF, 17, 3, 16'h2AAA);

      // Backpressure: result held while new requests are offered.
      wait_ready(2);
      i_a[2] = 16'd1000;
      v_a[2] = 1'b1;
      @(negedge clk);
      v_a[2] = 1'b0;
      for (int n = 0; n < 40 && !vo_a[2]; n++) @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         i_a[2] = 16'(k * 16'h1111);
         v_a[2] = k[0];
         @(negedge clk);
         chk("bp_v_o", 2, int'(vo_a[2]), 1);
         chk("bp_ready_o", 2, int'(ready_a[2]), 0);
         chk("bp_bank_o", 2, int'(bank_a[2]), 1);
         chk("bp_index_o", 2, int'(index_a[2]), 333);
      end
      v_a[2] = 1'b1;
      yumi_a[2] = 1'b1;
      @(negedge clk);
      yumi_a[2] = 1'b0;
      v_a[2] = 1'b0;
      chk("no_accept_with_yumi", 2, int'(ready_a[2]), 1);
      req(2, 16'h1234, 17, 1, 16'h0611);

      // Asynchronous reset in the middle of a division.
      wait_ready(2);
      i_a[2] = 16'hFFFF;
      v_a[2] = 1'b1;
      @(posedge clk);
      #1 v_a[2] = 1'b0;
      repeat (7) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("midreset_v_o", 2, int'(vo_a[2]), 0);
      chk("midreset_bank_o", 2, int'(bank_a[2]), 0);
      chk("midreset_index_o", 2, int'(index_a[2]), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_midreset", 2, int'(ready_a[2]), 1);
      chk("no_v_after_midreset", 2, int'(vo_a[2]), 0);
      req(2, 16'd9, 17, 0, 3);

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/bsg_hash_bank_iter.md
Name: bsg_hash_bank_iter

Overview:
- Parametrised successor to the combinational address-to-bank hash. Maps a width_p-bit address to bank = i mod banks_p and index = i div banks_p, for any banks_p ≥ 1, not only powers of two.
- Non-power-of-two bank counts use an iterative restoring divider. Power-of-two counts take a single-cycle bit-slice fast path.
- Sits between a requester and a banked memory array. Uses ready/valid on the input side and valid/yumi on the output side, with one request in flight.

Parameters:
- width_p, 16: address width in bits.
- banks_p, 1: number of banks; must satisfy 1 ≤ banks_p ≤ 2^width_p.
- lg_banks_lp, derived: max(1, clog2(banks_p)); width of bank_o.
- pow2_lp, derived: 1 when banks_p is a power of two (banks_p=1 included).

Ports:
- clk_i  in  1  clock, rising edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- i  in  width_p  address to hash.
- v_i  in  1  input valid.
- ready_o  out  1  input ready; a transfer occurs on an edge with v_i & ready_o.
- bank_o  out  lg_banks_lp  bank number, i mod banks_p.
- index_o  out  width_p  index within bank, i div banks_p, zero-extended.
- v_o  out  1  result valid.
- yumi_i  in  1  consumer takes result; legal only while v_o=1.

Behaviour:
- Reset (reset_n_i=0, asynchronous): state=IDLE; v_o=0, bank_o=0, index_o=0; ready_o=1 once reset deasserts; divider counter, remainder and quotient registers cleared.
- Reset mid-operation: the request in flight is discarded and no v_o is produced.
- States: IDLE, BUSY, DONE.
- IDLE:
  - ready_o=1, v_o=0.
  - On an edge with v_i=1, latch i.
  - If pow2_lp: go to DONE with bank_o=i[lg_banks_lp-1:0] (0 when banks_p=1) and index_o=i>>log2(banks_p).
  - Otherwise: go to BUSY; remainder=0, quotient=i, counter=0.
- BUSY:
  - ready_o=0, v_o=0.
  - Each edge performs one restoring step, MSB first: rem={rem,quot[msb]}; quot<<=1; if rem ≥ banks_p then rem-=banks_p and set quot[0]=1.
  - The remainder register is lg_banks_lp+1 bits wide, so no overflow is possible.
  - After the width_p-th step (counter = width_p-1 on that edge), go to DONE with index_o=quot and bank_o=rem[lg_banks_lp-1:0].
- DONE:
  - v_o=1, ready_o=0.
  - bank_o and index_o are held stable until yumi_i=1, then go to IDLE.
  - A new request is not accepted in the same cycle as yumi_i.
- Latency, from the accept edge to the first cycle with v_o=1:
  - pow2_lp: 1 cycle.
  - Otherwise: width_p+1 cycles (accept edge plus width_p BUSY edges; v_o is visible in the following cycle).
- Throughput: one result per (latency+1) cycles when yumi_i is asserted immediately.
- v_i while ready_o=0: ignored. i is sampled only on the accept edge, so later changes to i have no effect.
- yumi_i while v_o=0: protocol error; the simulation assertion fires and the design state is unchanged.
- Elaboration asserts: banks_p ≥ 1; banks_p ≤ 2^width_p.

Test Plan:
- width_p=16, banks_p=1: i=0xABCD, v_i=1 → next cycle v_o=1, bank_o=0, index_o=0xABCD; yumi_i → ready_o=1 on the following cycle.
- banks_p=4: i=0x1237 → after 1 cycle bank_o=3, index_o=0x048D.
- banks_p=3: i=0xFFFF → v_o rises exactly 17 cycles after the accept edge with bank_o=0, index_o=0x5555; then i=100 → bank_o=1, index_o=33.
- banks_p=6: i=5 → bank_o=5, index_o=0. Then i=0 → bank_o=0, index_o=0. Then i=0xFFFF → bank_o=3, index_o=0x2AAA.
- Backpressure, banks_p=3: hold yumi_i=0 for 5 cycles in DONE while toggling i and v_i → bank_o, index_o and v_o stay stable, ready_o=0, no new accept. After yumi_i, the next request completes correctly.
- Reset mid-BUSY, banks_p=3: drop reset_n_i at BUSY step 7 → v_o=0, bank_o=0 and index_o=0 immediately (asynchronous). After release, ready_o=1 and a fresh request i=9 gives bank_o=0, index_o=3.
